div_seq: RTL and testbench
==========================

# div_seq

Iterative 32-bit integer divider sequencer for the EX stage. It accepts a DIV/DIVU request from EX, stalls the pipeline while it runs a restoring shift-subtract loop, and returns {remainder, quotient}. EX forwards the result as hi/lo with whilo set into the EX/MEM register. One quotient bit is produced per cycle, and a single subtractor is reused across all 32 iterations.

## Interface
Parameters:
- none.

Ports:
- clk  input  1  clock; all state changes on the rising edge
- rst  input  1  asynchronous, active-low reset
- start_i  input  1  EX requests a divide; held high until ready_o is seen
- annul_i  input  1  abort the current operation (branch-slot flush / exception)
- signed_div_i  input  1  1 = DIV (signed), 0 = DIVU; sampled at acceptance
- opdata1_i  input  32  dividend; sampled at acceptance
- opdata2_i  input  32  divisor; sampled at acceptance
- result_o  output  64  {remainder[63:32], quotient[31:0]}; hi = [63:32], lo = [31:0]
- ready_o  output  1  result valid; EX uses it as whilo
- stallreq_o  output  1  stall request to pipeline control

## Operation
- States: FREE, BYZERO, ON, END. Reset state is FREE.
- Reset values: result_o = 0, ready_o = 0, stallreq_o = 0, iteration counter = 0.
- FREE:
  - start_i=1 and annul_i=0 is an acceptance: operands and signed flag are latched.
  - If the divisor is 0, go to BYZERO. Otherwise go to ON with the counter at 0.
- Operand preparation, signed mode: a negative operand is replaced by its two's complement, giving its absolute value as unsigned. The 65-bit work register is loaded with {32'b0, |dividend|, 1'b0}.
- ON, each cycle:
  - diff = work[64:32] − {1'b0, |divisor|}, computed 33 bits wide.
  - If diff[32]=1, shift work left by 1 and insert 0.
  - Otherwise set work = {diff[31:0], work[31:0], 1'b1}, shifted so the new quotient bit enters the LSB.
  - Increment the counter.
- After 32 iterations (counter = 32):
  - Quotient = work[31:0] and remainder = work[64:33].
  - Signed mode: negate the quotient if the operand signs differ. The remainder takes the sign of the dividend.
  - Write result_o, set ready_o=1, go to END.
- BYZERO: result_o = 0, ready_o = 1, go to END on the next edge.
- END:
  - Hold result_o and ready_o.
  - Leave for FREE when start_i=0, clearing ready_o. result_o holds its value.
- annul_i=1 in ON, BYZERO or END: go to FREE next edge. ready_o=0, result_o unchanged, counter cleared.
- annul_i has priority over every transition except reset.
- Operand changes after acceptance are ignored.
- stallreq_o = (state==FREE & start_i & ~annul_i) | state==BYZERO | state==ON. It is combinational from state and inputs, and forced to 0 while rst=0.
- Overflow case 0x80000000 / 0xFFFFFFFF (signed) is not special-cased. It yields quotient 0x80000000, remainder 0.

## Timing
- Acceptance edge E0 enters ON.
- Edges E1..E32 perform the 32 iterations.
- Edge E33 registers the result and ready_o.
- ready_o is high in the cycle after E33; stallreq_o is low in that same cycle.
- Divide by zero: ready_o is high after E1.
- ready_o stays high every cycle in END until the edge that samples start_i=0.
- Back-to-back operations need at least one FREE cycle between them.
- Asynchronous reset mid-operation clears all state and outputs immediately. No partial result is retained.

## Configuration
- DIV_SIGNED_EN defined:
  - Signed path compiled in as described.
  - signed_div_i is honoured.
- DIV_SIGNED_EN undefined:
  - Negation and sign-fix logic are removed.
  - signed_div_i is ignored and every operation is unsigned.
  - The port remains present.

## Test plan
- DIVU 100 / 7, start held: stallreq_o high for 34 cycles, then ready_o=1 with result_o hi=0x00000002, lo=0x0000000E. Drop start_i → FREE, ready_o=0.
- DIV −7 / 2 (0xFFFFFFF9 / 0x00000002): lo=0xFFFFFFFD, hi=0xFFFFFFFF. Without DIV_SIGNED_EN: lo=0x7FFFFFFC, hi=0x00000001.
- DIV 0x80000000 / 0xFFFFFFFF: lo=0x80000000, hi=0x00000000, no hang.
- DIVU 5 / 0: ready_o high after E1, result_o=0; stallreq_o low once in END.
- annul_i pulsed at iteration 10: FREE next edge, ready_o never asserts, stallreq_o=0. A following 9 / 3 gives lo=3, hi=0.
- rst driven low mid-operation (iteration 20): ready_o=0, stallreq_o=0, result_o=0 immediately. After release with start_i=0 the block sits in FREE.

Source files
------------

// File: rtl/div_seq.sv
// div_seq: iterative 32-bit restoring divider for the EX stage.
// One quotient bit per cycle, single shared subtractor, stalls pipeline.
//
// Ports:
//   clk, rst          clock, asynchronous active-low reset
//   start_i           divide request, held until ready_o
//   annul_i           abort the current operation
//   signed_div_i      1 = DIV, 0 = DIVU (sampled at acceptance)
//   opdata1_i         dividend (sampled at acceptance)
//   opdata2_i         divisor (sampled at acceptance)
//   result_o          {remainder, quotient}
//   ready_o           result valid (whilo)
//   stallreq_o        stall request to pipeline control
//
// Build option: DIV_SIGNED_EN compiles in the signed (DIV) path;
// without it every operation is unsigned and signed_div_i is ignored.

module div_seq (
    input  logic        clk,
    input  logic        rst,
    input  logic        start_i,
    input  logic        annul_i,
    input  logic        signed_div_i,
    input  logic [31:0] opdata1_i,
    input  logic [31:0] opdata2_i,
    output logic [63:0] result_o,
    output logic        ready_o,
    output logic        stallreq_o
);

    typedef enum logic [1:0] {
        FREE   = 2'd0,
        BYZERO = 2'd1,
        ON     = 2'd2,
        END    = 2'd3
    } state_t;

    state_t      state;
    state_t      state_nxt;

    logic [64:0] work;
    logic [31:0] dvs;
    logic [5:0]  cnt;
    logic [32:0] diff;
    logic        accept;
    logic        last;
    logic [31:0] abs1;
    logic [31:0] abs2;
    logic [31:0] quo;
    logic [31:0] rem;

    assign accept = start_i & ~annul_i;
    assign last   = (cnt == 6'd32);

    // 33-bit compare: the shifted partial remainder can exceed 32 bits
    assign diff = work[64:32] - {1'b0, dvs};

`ifdef DIV_SIGNED_EN
    logic neg1;
    logic neg2;
    logic neg_q;
    logic neg_r;

    assign neg1 = signed_div_i & opdata1_i[31];
    assign neg2 = signed_div_i & opdata2_i[31];
    assign abs1 = neg1 ? (~opdata1_i + 32'd1) : opdata1_i;
    assign abs2 = neg2 ? (~opdata2_i + 32'd1) : opdata2_i;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            neg_q <= 1'b0;
            neg_r <= 1'b0;
        end else if (state == FREE && accept) begin
            neg_q <= neg1 ^ neg2;
            neg_r <= neg1;
        end
    end

    // quotient negative on sign mismatch; remainder follows dividend
    assign quo = neg_q ? (~work[31:0] + 32'd1) : work[31:0];
    assign rem = neg_r ? (~work[64:33] + 32'd1) : work[64:33];
`else
    logic unused_sgn;

    assign unused_sgn = signed_div_i;
    assign abs1       = opdata1_i;
    assign abs2       = opdata2_i;
    assign quo        = work[31:0];
    assign rem        = work[64:33];
`endif

    // state register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= FREE;
        end else begin
            state <= state_nxt;
        end
    end

    // next-state logic; annul_i wins over every transition
    always_comb begin
        state_nxt = state;
        unique case (state)
            FREE: begin
                if (accept) begin
                    state_nxt = (opdata2_i == 32'd0) ? BYZERO : ON;
                end
            end
            BYZERO: begin
                state_nxt = annul_i ? FREE : END;
            end
            ON: begin
                if (annul_i) begin
                    state_nxt = FREE;
                end else if (last) begin
                    state_nxt = END;
                end
            end
            END: begin
                if (annul_i || !start_i) begin
                    state_nxt = FREE;
                end
            end
            default: state_nxt = FREE;
        endcase
    end

    // output logic
    always_comb begin
        stallreq_o = 1'b0;
        if (rst) begin
            unique case (state)
                FREE:       stallreq_o = accept;
                BYZERO, ON: stallreq_o = 1'b1;
                default:    stallreq_o = 1'b0;
            endcase
        end
    end

    // datapath: operand latch, shift-subtract loop, result register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            work     <= 65'd0;
            dvs      <= 32'd0;
            cnt      <= 6'd0;
            result_o <= 64'd0;
            ready_o  <= 1'b0;
        end else begin
            unique case (state)
                FREE: begin
                    if (accept) begin
                        work <= {32'd0, abs1, 1'b0};
                        dvs  <= abs2;
                        cnt  <= 6'd0;
                    end
                end
                BYZERO: begin
                    if (annul_i) begin
                        ready_o <= 1'b0;
                        cnt     <= 6'd0;
                    end else begin
                        result_o <= 64'd0;
                        ready_o  <= 1'b1;
                    end
                end
                ON: begin
                    if (annul_i) begin
                        ready_o <= 1'b0;
                        cnt     <= 6'd0;
                    end else if (last) begin
                        result_o <= {rem, quo};
                        ready_o  <= 1'b1;
                        cnt      <= 6'd0;
                    end else begin
                        if (diff[32]) begin
                            work <= {work[63:0], 1'b0};
                        end else begin
                            work <= {diff[31:0], work[31:0], 1'b1};
                        end
                        cnt <= cnt + 6'd1;
                    end
                end
                END: begin
                    if (annul_i || !start_i) begin
                        ready_o <= 1'b0;
                        cnt     <= 6'd0;
                    end
                end
                default: begin
                    ready_o <= 1'b0;
                    cnt     <= 6'd0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_div_seq.sv
// tb_div_seq: directed scoreboard bench for div_seq.
// Expected results come from a behavioural division model.

module tb_div_seq;

`ifdef DIV_SIGNED_EN
    localparam bit SGN = 1'b1;
`else
    localparam bit SGN = 1'b0;
`endif

    logic        clk;
    logic        rst;
    logic        start_i;
    logic        annul_i;
    logic        signed_div_i;
    logic [31:0] opdata1_i;
    logic [31:0] opdata2_i;
    logic [63:0] result_o;
    logic        ready_o;
    logic        stallreq_o;

    int          errors;
    int          checks;
    logic [63:0] sb[$];
    logic [63:0] last_res;

    div_seq dut (
        .clk          (clk),
        .rst          (rst),
        .start_i      (start_i),
        .annul_i      (annul_i),
        .signed_div_i (signed_div_i),
        .opdata1_i    (opdata1_i),
        .opdata2_i    (opdata2_i),
        .result_o     (result_o),
        .ready_o      (ready_o),
        .stallreq_o   (stallreq_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [63:0] model(
        input logic [31:0] a,
        input logic [31:0] b,
        input logic        sg
    );
        longint sa;
        longint sbv;
        longint q;
        longint r;
        logic [63:0] res;
        if (b == 32'd0) return 64'd0;
        if (sg && SGN) begin
            sa  = longint'($signed(a));
            sbv = longint'($signed(b));
            q   = sa / sbv;
            r   = sa % sbv;
            res = {r[31:0], q[31:0]};
        end else begin
            res = {a % b, a / b};
        end
        return res;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // one complete request: accept, wait for ready, hold, release
    task automatic do_div(input logic [31:0] a, input logic [31:0] b,
                          input logic sg, input int exp_stall,
                          input string tag);
        int          n;
        logic        got;
        logic [63:0] e;
        sb.push_back(model(a, b, sg));
        opdata1_i    = a;
        opdata2_i    = b;
        signed_div_i = sg;
        start_i      = 1'b1;
        #1;
        n   = stallreq_o ? 1 : 0;
        got = 1'b0;
        for (int i = 0; i < 100 && !got; i++) begin
            @(negedge clk);
            if (ready_o) got = 1'b1;
            else if (stallreq_o) n++;
            if (i == 0) begin
                opdata1_i    = $urandom;
                opdata2_i    = $urandom;
                signed_div_i = ~sg;
            end
        end
        chk({tag, "_ready_seen"}, 64'(got), 64'd1);
        e = sb.pop_front();
        if (got) begin
            chk({tag, "_result"}, result_o, e);
            chk({tag, "_stall_cycles"}, 64'(n), 64'(exp_stall));
            chk({tag, "_stall_low_at_ready"}, 64'(stallreq_o), 64'd0);
            @(negedge clk);
            chk({tag, "_ready_held"}, 64'(ready_o), 64'd1);
            chk({tag, "_result_held"}, result_o, e);
            start_i = 1'b0;
            @(negedge clk);
            chk({tag, "_ready_cleared"}, 64'(ready_o), 64'd0);
            chk({tag, "_result_kept"}, result_o, e);
            chk({tag, "_stall_free"}, 64'(stallreq_o), 64'd0);
            last_res = e;
        end else begin
            start_i = 1'b0;
            @(negedge clk);
        end
    endtask

    initial begin
        errors       = 0;
        checks       = 0;
        last_res     = 64'd0;
        rst          = 1'b0;
        start_i      = 1'b1;
        annul_i      = 1'b0;
        signed_div_i = 1'b0;
        opdata1_i    = 32'd100;
        opdata2_i    = 32'd7;
        repeat (2) @(negedge clk);
        chk("rst_ready", 64'(ready_o), 64'd0);
        chk("rst_stall", 64'(stallreq_o), 64'd0);
        chk("rst_result", result_o, 64'd0);
        start_i = 1'b0;
        rst     = 1'b1;
        @(negedge clk);
        chk("idle_stall", 64'(stallreq_o), 64'd0);

        do_div(32'd100, 32'd7, 1'b0, 34, "divu_100_7");
        do_div(32'hFFFF_FFF9, 32'd2, 1'b1, 34, "div_m7_2");
        do_div(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 34, "div_ovf");
        do_div(32'hFFFF_FFFF, 32'h8000_0001, 1'b0, 34, "divu_bigdvs");
        do_div(32'd5, 32'd0, 1'b0, 2, "divu_by0");
        do_div(32'd7, 32'hFFFF_FFFE, 1'b1, 34, "div_7_m2");
        do_div(32'd3, 32'd10, 1'b0, 34, "divu_small");
        for (int k = 0; k < 3; k++) begin
            do_div($urandom, $urandom_range(1, 1000), 1'(k), 34,
                   "rand");
        end

        // abort at iteration 10
        opdata1_i    = 32'd50;
        opdata2_i    = 32'd3;
        signed_div_i = 1'b0;
        start_i      = 1'b1;
        @(negedge clk);
        repeat (10) @(negedge clk);
        annul_i = 1'b1;
        @(negedge clk);
        chk("annul_ready", 64'(ready_o), 64'd0);
        chk("annul_stall", 64'(stallreq_o), 64'd0);
        chk("annul_result", result_o, last_res);
        annul_i = 1'b0;
        start_i = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (ready_o) break;
        end
        chk("annul_no_ready", 64'(ready_o), 64'd0);
        do_div(32'd9, 32'd3, 1'b0, 34, "after_annul_9_3");

        // asynchronous reset at iteration 20
        opdata1_i = 32'd1000;
        opdata2_i = 32'd9;
        start_i   = 1'b1;
        @(negedge clk);
        repeat (20) @(negedge clk);
        #2;
        rst = 1'b0;
        #1;
        chk("arst_ready", 64'(ready_o), 64'd0);
        chk("arst_stall", 64'(stallreq_o), 64'd0);
        chk("arst_result", result_o, 64'd0);
        start_i = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        repeat (40) @(negedge clk);
        chk("post_rst_ready", 64'(ready_o), 64'd0);
        chk("post_rst_stall", 64'(stallreq_o), 64'd0);
        chk("post_rst_result", result_o, 64'd0);
        do_div(32'd100, 32'd7, 1'b0, 34, "post_rst_100_7");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
